// File: rtl/dcache_pkg.sv
// Shared types for the L1 data cache: FSM state encoding and a field-width helper.
package dcache_pkg;

  typedef enum logic [1:0] {
    DC_IDLE,
    DC_WB,
    DC_FILL,
    DC_FILL_WAIT
  } dcache_state_t;

  // Byte-offset bits below the word index (32-bit words).
  localparam int unsigned DC_OFF_BITS = 2;

  // Tag width left over once byte, word and index fields are carved out.
  function automatic int unsigned dc_tag_bits(input int unsigned aw,
                                              input int unsigned lw,
                                              input int unsigned nl);
    return aw - DC_OFF_BITS - $clog2(lw) - $clog2(nl);
  endfunction

endpackage

// File: rtl/dcache_ram.sv
// Storage for the data cache: valid/dirty bits (reset), tag array and data
// array (not reset). Asynchronous reads of a whole line, synchronous writes
// with per-byte enables on the data array and a single metadata write port.
module dcache_ram
  import dcache_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LINE_WORDS = 4,
  parameter int NUM_LINES  = 64,
  parameter int TAG_BITS   = 22,
  localparam int IDX_BITS  = $clog2(NUM_LINES),
  localparam int WORD_BITS = $clog2(LINE_WORDS),
  localparam int BE_WIDTH  = DATA_WIDTH / 8
) (
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic [IDX_BITS-1:0]              rd_idx,
  output logic                             rd_valid,
  output logic                             rd_dirty,
  output logic [TAG_BITS-1:0]              rd_tag,
  output logic [LINE_WORDS*DATA_WIDTH-1:0] rd_line,
  input  logic                             data_we,
  input  logic [IDX_BITS-1:0]              data_idx,
  input  logic [WORD_BITS-1:0]             data_word,
  input  logic [DATA_WIDTH-1:0]            data_wdata,
  input  logic [BE_WIDTH-1:0]              data_be,
  input  logic                             meta_we,
  input  logic [IDX_BITS-1:0]              meta_idx,
  input  logic                             meta_valid,
  input  logic                             meta_dirty,
  input  logic [TAG_BITS-1:0]              meta_tag
);

  logic [NUM_LINES-1:0]  valid_q, valid_d;
  logic [NUM_LINES-1:0]  dirty_q, dirty_d;
  logic [TAG_BITS-1:0]   tag_mem  [NUM_LINES];
  logic [DATA_WIDTH-1:0] data_mem [NUM_LINES*LINE_WORDS];

  // Next valid/dirty state from the metadata write port
  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    if (meta_we) begin
      valid_d[meta_idx] = meta_valid;
      dirty_d[meta_idx] = meta_dirty;
    end
  end

  // Valid/dirty flops: cleared by reset so no line survives an aborted fill
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  // Tag array write, no reset
  always_ff @(posedge clock) begin
    if (meta_we) tag_mem[meta_idx] <= meta_tag;
  end

  // Data array byte-masked write, no reset
  always_ff @(posedge clock) begin
    if (data_we) begin
      for (int b = 0; b < BE_WIDTH; b++) begin
        if (data_be[b]) data_mem[{data_idx, data_word}][b*8 +: 8] <= data_wdata[b*8 +: 8];
      end
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_dirty = dirty_q[rd_idx];
  assign rd_tag   = tag_mem[rd_idx];

  for (genvar w = 0; w < LINE_WORDS; w++) begin : g_rd
    assign rd_line[w*DATA_WIDTH +: DATA_WIDTH] = data_mem[{rd_idx, WORD_BITS'(w)}];
  end

endmodule

// File: rtl/dcache.sv
// Direct-mapped write-back / write-allocate L1 data cache. Hits complete in
// the same cycle; misses stall the CPU while the FSM writes back a dirty
// victim and refills the line one word at a time.
// Optional build macro DCACHE_STATS_EN adds hit_count/miss_count ports.
module dcache
  import dcache_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LINE_WORDS = 4,
  parameter int NUM_LINES  = 64,
  localparam int BE_WIDTH  = DATA_WIDTH / 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  cpu_rd,
  input  logic                  cpu_wr,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wr_data,
  input  logic [BE_WIDTH-1:0]   cpu_wr_be,
  output logic [DATA_WIDTH-1:0] cpu_rd_data,
  output logic                  cpu_waitrequest,
  output logic                  mem_rd,
  output logic                  mem_wr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  input  logic                  mem_waitrequest,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  input  logic                  mem_rd_valid
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count
`endif
);

  localparam int WORD_BITS = $clog2(LINE_WORDS);
  localparam int IDX_BITS  = $clog2(NUM_LINES);
  localparam int TAG_BITS  = dc_tag_bits(ADDR_WIDTH, LINE_WORDS, NUM_LINES);
  localparam int IDX_LSB   = DC_OFF_BITS + WORD_BITS;
  localparam int TAG_LSB   = IDX_LSB + IDX_BITS;
  localparam logic [WORD_BITS-1:0] K_LAST = WORD_BITS'(LINE_WORDS - 1);

  // Address fields of the current CPU request
  logic [WORD_BITS-1:0] cpu_word;
  logic [IDX_BITS-1:0]  cpu_idx;
  logic [TAG_BITS-1:0]  cpu_tag;
  logic                 unused_byte_off;
  assign cpu_word        = cpu_addr[DC_OFF_BITS +: WORD_BITS];
  assign cpu_idx         = cpu_addr[IDX_LSB +: IDX_BITS];
  assign cpu_tag         = cpu_addr[TAG_LSB +: TAG_BITS];
  assign unused_byte_off = ^cpu_addr[DC_OFF_BITS-1:0];

  // FSM and registered memory-port state
  dcache_state_t           state_q, state_d;
  logic [WORD_BITS-1:0]    k_q, k_d;
  logic [IDX_BITS-1:0]     idx_q, idx_d;
  logic [TAG_BITS-1:0]     tag_q, tag_d;
  logic [TAG_BITS-1:0]     vtag_q, vtag_d;
  logic                    mem_rd_q, mem_rd_d;
  logic                    mem_wr_q, mem_wr_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]   mem_wr_data_q, mem_wr_data_d;

  // Storage interface
  logic                             rd_valid, rd_dirty;
  logic [TAG_BITS-1:0]              rd_tag;
  logic [LINE_WORDS*DATA_WIDTH-1:0] rd_line;
  logic [DATA_WIDTH-1:0]            line_w [LINE_WORDS];
  logic [IDX_BITS-1:0]              rd_idx;
  logic                             data_we, meta_we, meta_valid, meta_dirty;
  logic [IDX_BITS-1:0]              data_idx, meta_idx;
  logic [WORD_BITS-1:0]             data_word;
  logic [DATA_WIDTH-1:0]            data_wdata;
  logic [BE_WIDTH-1:0]              data_be;
  logic [TAG_BITS-1:0]              meta_tag;

  logic                 req, hit;
  logic [WORD_BITS-1:0] k_nx;

  // While a miss is in flight the held request has the same index anyway,
  // but the latched copy keeps the victim line selected regardless.
  assign rd_idx = (state_q == DC_IDLE) ? cpu_idx : idx_q;

  dcache_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .LINE_WORDS (LINE_WORDS),
    .NUM_LINES  (NUM_LINES),
    .TAG_BITS   (TAG_BITS)
  ) u_ram (
    .clock      (clock),
    .reset_n    (reset_n),
    .rd_idx     (rd_idx),
    .rd_valid   (rd_valid),
    .rd_dirty   (rd_dirty),
    .rd_tag     (rd_tag),
    .rd_line    (rd_line),
    .data_we    (data_we),
    .data_idx   (data_idx),
    .data_word  (data_word),
    .data_wdata (data_wdata),
    .data_be    (data_be),
    .meta_we    (meta_we),
    .meta_idx   (meta_idx),
    .meta_valid (meta_valid),
    .meta_dirty (meta_dirty),
    .meta_tag   (meta_tag)
  );

  for (genvar w = 0; w < LINE_WORDS; w++) begin : g_line
    assign line_w[w] = rd_line[w*DATA_WIDTH +: DATA_WIDTH];
  end

  assign req             = cpu_rd | cpu_wr;
  assign hit             = rd_valid & (rd_tag == cpu_tag);
  assign k_nx            = k_q + 1'b1;
  assign cpu_rd_data     = line_w[cpu_word];
  assign cpu_waitrequest = (state_q != DC_IDLE) | (req & ~hit);
  assign mem_rd          = mem_rd_q;
  assign mem_wr          = mem_wr_q;
  assign mem_addr        = mem_addr_q;
  assign mem_wr_data     = mem_wr_data_q;

  // Next-state, memory-port and storage-write decode for the miss FSM
  always_comb begin
    state_d       = state_q;
    k_d           = k_q;
    idx_d         = idx_q;
    tag_d         = tag_q;
    vtag_d        = vtag_q;
    mem_rd_d      = mem_rd_q;
    mem_wr_d      = mem_wr_q;
    mem_addr_d    = mem_addr_q;
    mem_wr_data_d = mem_wr_data_q;
    data_we       = 1'b0;
    data_idx      = idx_q;
    data_word     = k_q;
    data_wdata    = mem_rd_data;
    data_be       = '1;
    meta_we       = 1'b0;
    meta_idx      = idx_q;
    meta_valid    = 1'b0;
    meta_dirty    = 1'b0;
    meta_tag      = tag_q;
    case (state_q)
      DC_IDLE: begin
        if (req && hit) begin
          if (cpu_wr) begin
            data_we    = 1'b1;
            data_idx   = cpu_idx;
            data_word  = cpu_word;
            data_wdata = cpu_wr_data;
            data_be    = cpu_wr_be;
            meta_we    = 1'b1;
            meta_idx   = cpu_idx;
            meta_valid = 1'b1;
            meta_dirty = 1'b1;
            meta_tag   = cpu_tag;
          end
        end else if (req) begin
          idx_d  = cpu_idx;
          tag_d  = cpu_tag;
          vtag_d = rd_tag;
          k_d    = '0;
          if (rd_valid && rd_dirty) begin
            state_d       = DC_WB;
            mem_wr_d      = 1'b1;
            mem_addr_d    = {rd_tag, cpu_idx, {WORD_BITS{1'b0}}, 2'b00};
            mem_wr_data_d = line_w[0];
          end else begin
            // Clean victim: drop it now so a partial fill is never valid
            state_d    = DC_FILL;
            mem_rd_d   = 1'b1;
            mem_addr_d = {cpu_tag, cpu_idx, {WORD_BITS{1'b0}}, 2'b00};
            meta_we    = 1'b1;
            meta_idx   = cpu_idx;
            meta_tag   = rd_tag;
          end
        end
      end
      DC_WB: begin
        if (!mem_waitrequest) begin
          if (k_q == K_LAST) begin
            // Victim is in memory: invalidate and start the refill
            meta_we    = 1'b1;
            meta_tag   = vtag_q;
            mem_wr_d   = 1'b0;
            mem_rd_d   = 1'b1;
            mem_addr_d = {tag_q, idx_q, {WORD_BITS{1'b0}}, 2'b00};
            k_d        = '0;
            state_d    = DC_FILL;
          end else begin
            k_d           = k_nx;
            mem_addr_d    = {vtag_q, idx_q, k_nx, 2'b00};
            mem_wr_data_d = line_w[k_nx];
          end
        end
      end
      DC_FILL: begin
        if (!mem_waitrequest) begin
          mem_rd_d = 1'b0;
          state_d  = DC_FILL_WAIT;
        end
      end
      DC_FILL_WAIT: begin
        if (mem_rd_valid) begin
          data_we = 1'b1;
          if (k_q == K_LAST) begin
            meta_we    = 1'b1;
            meta_valid = 1'b1;
            state_d    = DC_IDLE;
          end else begin
            k_d        = k_nx;
            mem_rd_d   = 1'b1;
            mem_addr_d = {tag_q, idx_q, k_nx, 2'b00};
            state_d    = DC_FILL;
          end
        end
      end
      default: state_d = DC_IDLE;
    endcase
  end

  // FSM state and registered memory-port outputs; reset aborts any transfer
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= DC_IDLE;
      k_q           <= '0;
      idx_q         <= '0;
      tag_q         <= '0;
      vtag_q        <= '0;
      mem_rd_q      <= 1'b0;
      mem_wr_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wr_data_q <= '0;
    end else begin
      state_q       <= state_d;
      k_q           <= k_d;
      idx_q         <= idx_d;
      tag_q         <= tag_d;
      vtag_q        <= vtag_d;
      mem_rd_q      <= mem_rd_d;
      mem_wr_q      <= mem_wr_d;
      mem_addr_q    <= mem_addr_d;
      mem_wr_data_q <= mem_wr_data_d;
    end
  end

`ifdef DCACHE_STATS_EN
  logic        retry_q, retry_d;
  logic [31:0] hit_count_q, hit_count_d;
  logic [31:0] miss_count_q, miss_count_d;

  // Count first-time hits and misses; the retry right after a fill is not a hit
  always_comb begin
    retry_d      = retry_q;
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (state_q == DC_IDLE) begin
      retry_d = 1'b0;
      if (req && hit && !retry_q) hit_count_d = hit_count_q + 32'd1;
      if (req && !hit) miss_count_d = miss_count_q + 32'd1;
    end else if (state_q == DC_FILL_WAIT && mem_rd_valid && k_q == K_LAST) begin
      retry_d = 1'b1;
    end
  end

  // Statistics registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      retry_q      <= 1'b0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      retry_q      <= retry_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_dcache.sv
// Scoreboard bench for dcache: stimulus pushes expected CPU read data and
// expected memory-port operations; monitors pop and compare as the DUT
// presents them. A small memory model answers fills with configurable stall.
module tb_dcache;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        cpu_rd, cpu_wr;
  logic [31:0] cpu_addr, cpu_wr_data;
  logic [3:0]  cpu_wr_be;
  logic [31:0] cpu_rd_data;
  logic        cpu_waitrequest;
  logic        mem_rd, mem_wr;
  logic [31:0] mem_addr, mem_wr_data;
  logic        mem_waitrequest;
  logic [31:0] mem_rd_data;
  logic        mem_rd_valid;
`ifdef DCACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  dcache dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .cpu_rd          (cpu_rd),
    .cpu_wr          (cpu_wr),
    .cpu_addr        (cpu_addr),
    .cpu_wr_data     (cpu_wr_data),
    .cpu_wr_be       (cpu_wr_be),
    .cpu_rd_data     (cpu_rd_data),
    .cpu_waitrequest (cpu_waitrequest),
    .mem_rd          (mem_rd),
    .mem_wr          (mem_wr),
    .mem_addr        (mem_addr),
    .mem_wr_data     (mem_wr_data),
    .mem_waitrequest (mem_waitrequest),
    .mem_rd_data     (mem_rd_data),
    .mem_rd_valid    (mem_rd_valid)
`ifdef DCACHE_STATS_EN
    ,
    .hit_count       (hit_count),
    .miss_count      (miss_count)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } mem_op_t;

  mem_op_t     exp_mem[$];
  logic [31:0] exp_rd[$];
  logic [31:0] mem_model [logic [31:0]];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          stall_cfg = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Untouched memory words read back as address ^ 5A5A0000
  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return a ^ 32'h5A5A0000;
  endfunction

  // Memory responder: samples the request at negedge, answers just after posedge
  initial begin
    logic        s_rd, s_wr, s_wt;
    logic [31:0] s_a, s_d;
    int          wcnt;
    wcnt            = 0;
    mem_rd_valid    = 1'b0;
    mem_rd_data     = '0;
    mem_waitrequest = 1'b0;
    forever begin
      @(negedge clock);
      s_rd = mem_rd; s_wr = mem_wr; s_a = mem_addr; s_d = mem_wr_data; s_wt = mem_waitrequest;
      @(posedge clock);
      #1;
      mem_rd_valid = 1'b0;
      if (s_rd || s_wr) begin
        if (!s_wt) begin
          wcnt = 0;
          if (s_wr) mem_model[s_a] = s_d;
          else begin
            mem_rd_valid = 1'b1;
            mem_rd_data  = mem_read(s_a);
          end
        end else wcnt++;
      end
      mem_waitrequest = (wcnt < stall_cfg);
    end
  end

  // CPU-side monitor: every completing load is checked against the scoreboard
  initial begin
    forever begin
      @(negedge clock);
      if (reset_n && cpu_rd && !cpu_wr && !cpu_waitrequest) begin
        if (exp_rd.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL cpu_rd_unexpected: got %h expected none", cpu_rd_data);
        end else check("cpu_rd_data", cpu_rd_data, exp_rd.pop_front());
      end
    end
  end

  // Memory-side monitor: accepted ops vs scoreboard, and stability while stalled
  initial begin
    logic        hold_v, h_rd, h_wr;
    logic [31:0] h_a, h_d;
    mem_op_t     e;
    hold_v = 1'b0; h_rd = 1'b0; h_wr = 1'b0; h_a = '0; h_d = '0;
    forever begin
      @(negedge clock);
      if (!reset_n) hold_v = 1'b0;
      else begin
        if (hold_v) begin
          check("hold_mem_rd", 32'(mem_rd), 32'(h_rd));
          check("hold_mem_wr", 32'(mem_wr), 32'(h_wr));
          check("hold_mem_addr", mem_addr, h_a);
          if (h_wr) check("hold_mem_wr_data", mem_wr_data, h_d);
        end
        hold_v = (mem_rd || mem_wr) && mem_waitrequest;
        h_rd = mem_rd; h_wr = mem_wr; h_a = mem_addr; h_d = mem_wr_data;
        if ((mem_rd || mem_wr) && !mem_waitrequest) begin
          if (exp_mem.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL mem_op_unexpected: got wr=%0b addr=%h expected none", mem_wr, mem_addr);
          end else begin
            e = exp_mem.pop_front();
            check("mem_op_is_wr", 32'(mem_wr), 32'(e.wr));
            check("mem_op_addr", mem_addr, e.addr);
            if (e.wr) check("mem_op_wr_data", mem_wr_data, e.data);
          end
        end
      end
    end
  end

  task automatic push_line(input logic wr, input logic [31:0] base, input logic [31:0] d0,
                           input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] d3);
    exp_mem.push_back('{wr, base,         d0});
    exp_mem.push_back('{wr, base + 32'h4, d1});
    exp_mem.push_back('{wr, base + 32'h8, d2});
    exp_mem.push_back('{wr, base + 32'hC, d3});
  endtask

  // One CPU access held until waitrequest drops (bounded)
  task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] be, input logic exp_miss);
    bit done;
    @(posedge clock); #1;
    cpu_rd = rd; cpu_wr = wr; cpu_addr = a; cpu_wr_data = d; cpu_wr_be = be;
    #1;
    check("waitrequest_on_issue", 32'(cpu_waitrequest), 32'(exp_miss));
    done = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clock);
      if (!cpu_waitrequest) begin done = 1'b1; break; end
    end
    if (!done) begin
      n_tests++; n_fail++;
      $display("FAIL access_timeout: addr %h still stalled, expected completion", a);
    end
    @(posedge clock); #1;
    cpu_rd = 1'b0; cpu_wr = 1'b0;
  endtask

`ifdef DCACHE_STATS_EN
  task automatic check_stats(input int h, input int m);
    check("hit_count", hit_count, 32'(h));
    check("miss_count", miss_count, 32'(m));
  endtask
`endif

  initial begin
    int nval;
    cpu_rd = 0; cpu_wr = 0; cpu_addr = '0; cpu_wr_data = '0; cpu_wr_be = '0;
    reset_n = 1'b0;
    mem_model[32'h100] = 32'h11111111;
    mem_model[32'h104] = 32'h22222222;
    mem_model[32'h108] = 32'h33333333;
    mem_model[32'h10C] = 32'h44444444;
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;

    // Reset / idle state
    @(negedge clock);
    check("rst_waitrequest", 32'(cpu_waitrequest), 32'd0);
    check("rst_mem_rd", 32'(mem_rd), 32'd0);
    check("rst_mem_wr", 32'(mem_wr), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wr_data", mem_wr_data, 32'd0);
`ifdef DCACHE_STATS_EN
    check_stats(0, 0);
`endif

    // Cold read of 0x0
    push_line(1'b0, 32'h0, 0, 0, 0, 0);
    exp_rd.push_back(32'h5A5A0000);
    access(1, 0, 32'h0, 0, 4'h0, 1);
`ifdef DCACHE_STATS_EN
    check_stats(0, 1);
`endif

    // Cold read of 0x100 refills 0x100..0x10C
    push_line(1'b0, 32'h100, 0, 0, 0, 0);
    exp_rd.push_back(32'h11111111);
    access(1, 0, 32'h100, 0, 4'h0, 1);
`ifdef DCACHE_STATS_EN
    check_stats(0, 2);
`endif

    // Byte store hit (be[2] = bits 23:16), then hit reads
    access(0, 1, 32'h101, 32'h00AB0000, 4'b0100, 0);
    exp_rd.push_back(32'h11AB1111);
    access(1, 0, 32'h100, 0, 4'h0, 0);
    exp_rd.push_back(32'h44444444);
    access(1, 0, 32'h10C, 0, 4'h0, 0);
`ifdef DCACHE_STATS_EN
    check_stats(3, 2);
`endif

    // Conflict miss on dirty line: write back 0x100 line, then fill 0x500
    push_line(1'b1, 32'h100, 32'h11AB1111, 32'h22222222, 32'h33333333, 32'h44444444);
    push_line(1'b0, 32'h500, 0, 0, 0, 0);
    exp_rd.push_back(32'h5A5A0500);
    access(1, 0, 32'h500, 0, 4'h0, 1);

    // Slow memory: 3 stall cycles per word across write-back and fill
    stall_cfg = 3;
    access(0, 1, 32'h504, 32'hCAFEF00D, 4'hF, 0);
    push_line(1'b1, 32'h500, 32'h5A5A0500, 32'hCAFEF00D, 32'h5A5A0508, 32'h5A5A050C);
    push_line(1'b0, 32'h900, 0, 0, 0, 0);
    exp_rd.push_back(32'h5A5A0900);
    access(1, 0, 32'h900, 0, 4'h0, 1);
    stall_cfg = 0;
    check("mem_model_504", mem_read(32'h504), 32'hCAFEF00D);

    // rd & wr together behaves as a store
    access(1, 1, 32'h908, 32'h12345678, 4'hF, 0);
    exp_rd.push_back(32'h12345678);
    access(1, 0, 32'h908, 0, 4'h0, 0);
`ifdef DCACHE_STATS_EN
    check_stats(6, 4);
`endif

    // Reset in the middle of a fill of 0x200, after the 2nd word arrives
    exp_mem.push_back('{1'b0, 32'h200, 32'h0});
    exp_mem.push_back('{1'b0, 32'h204, 32'h0});
    @(posedge clock); #1;
    cpu_rd = 1'b1; cpu_addr = 32'h200;
    nval = 0;
    for (int i = 0; i < 100 && nval < 2; i++) begin
      @(negedge clock);
      if (mem_rd_valid) nval++;
    end
    check("fill_words_before_reset", 32'(nval), 32'd2);
    @(posedge clock); #2;
    reset_n = 1'b0; cpu_rd = 1'b0;
    #1;
    check("rst_mid_mem_rd", 32'(mem_rd), 32'd0);
    check("rst_mid_mem_addr", mem_addr, 32'd0);
    check("rst_mid_waitrequest", 32'(cpu_waitrequest), 32'd0);
    @(posedge clock); #1 reset_n = 1'b1;

    // 0x100 misses again after reset; dirty 0x900 line was dropped, no write-back
    push_line(1'b0, 32'h100, 0, 0, 0, 0);
    exp_rd.push_back(32'h11AB1111);
    access(1, 0, 32'h100, 0, 4'h0, 1);
`ifdef DCACHE_STATS_EN
    check_stats(0, 1);
`endif

    repeat (4) @(negedge clock);
    check("exp_mem_drained", 32'(exp_mem.size()), 32'd0);
    check("exp_rd_drained", 32'(exp_rd.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
